tlul_host_arb2: RTL and testbench

Two-host TileLink-UL (TL-UL) arbiter that shares one device-side TL-UL port between the core's instruction-fetch FIFO and data FIFO. It sits between the two core-side `tlul_fifo_sync` instances and the single crossbar host port. It arbitrates the A channel with grant locking, tags each request's source with the host index, and routes D-channel responses back by that tag. Per-host outstanding counters throttle each host independently.

---
 rtl/tlul_host_arb2.sv | 183 ++++++++++++++++++
 tb/tb_tlul_host_arb2.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_host_arb2.sv
// Two-host TL-UL arbiter: shares one device port between instr (host 0) and data (host 1) FIFOs.
// Define TLUL_ARB_RR_EN for round-robin arbitration; default is fixed priority (host 1 wins).
module tlul_host_arb2 #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [101:0] tl_h0_i,
    output logic [67:0]  tl_h0_o,
    input  logic [101:0] tl_h1_i,
    output logic [67:0]  tl_h1_o,
    output logic [101:0] tl_d_o,
    input  logic [67:0]  tl_d_i,
    output logic         busy_o
);

    localparam int unsigned CntW = 4;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } d2h_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic [1:0][CntW-1:0] cnt_q, cnt_d;
`ifdef TLUL_ARB_RR_EN
    logic                 rr_q, rr_d;
`endif

    h2d_t [1:0] host;
    d2h_t       dev;
    h2d_t       req;
    d2h_t [1:0] rsp;

    logic [1:0] eligible;
    logic [1:0] a_hs;
    logic [1:0] d_hs;
    logic       win;
    logic       granted;
    logic       gnt_idx;
    logic       a_fire;
    logic       d_sel;
    logic       unused_src;

    assign host    = {tl_h1_i, tl_h0_i};
    assign dev     = tl_d_i;
    assign tl_d_o  = req;
    assign tl_h0_o = rsp[0];
    assign tl_h1_o = rsp[1];
    assign d_sel   = dev.d_source[7];
    assign busy_o  = (cnt_q[0] != '0) || (cnt_q[1] != '0);

    // Bit 7 of the host source is overwritten by the host index.
    assign unused_src = host[0].a_source[7] ^ host[1].a_source[7];

    // Grant selection, A/D steering and next-state logic.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        granted  = 1'b0;
        gnt_idx  = 1'b0;
        req      = '0;
        rsp      = '0;
        a_hs     = '0;
        d_hs     = '0;
        eligible = '0;
`ifdef TLUL_ARB_RR_EN
        rr_d     = rr_q;
`endif

        for (int k = 0; k < 2; k++) begin
            eligible[k] = host[k].a_valid && (cnt_q[k] < CntW'(MaxOutstanding));
        end

`ifdef TLUL_ARB_RR_EN
        win = (&eligible) ? rr_q : eligible[1];
`else
        win = eligible[1];
`endif

        case (state_q)
            IDLE: begin
                granted = |eligible;
                gnt_idx = win;
            end
            HOLD: begin
                granted = 1'b1;
                gnt_idx = gnt_q;
            end
            default: ;
        endcase

        a_fire = granted && host[gnt_idx].a_valid && dev.a_ready;

        if (state_q == IDLE && granted && !a_fire) begin
            state_d = HOLD;
            gnt_d   = gnt_idx;
        end else if (state_q == HOLD && a_fire) begin
            state_d = IDLE;
        end

`ifdef TLUL_ARB_RR_EN
        if (a_fire) begin
            rr_d = ~gnt_idx;
        end
`endif

        if (granted) begin
            req          = host[gnt_idx];
            req.a_source = {gnt_idx, host[gnt_idx].a_source[6:0]};
        end
        req.d_ready = host[d_sel].d_ready;

        for (int k = 0; k < 2; k++) begin
            if (d_sel == 1'(k)) begin
                rsp[k]             = dev;
                rsp[k].d_source[7] = 1'b0;
                rsp[k].a_ready     = 1'b0;
            end
            if (granted && gnt_idx == 1'(k)) begin
                rsp[k].a_ready = dev.a_ready;
            end

            a_hs[k] = a_fire && (gnt_idx == 1'(k));
            d_hs[k] = dev.d_valid && (d_sel == 1'(k)) && host[k].d_ready;

            // A response at count 0 is still forwarded; the count holds at 0.
            if (a_hs[k] && !d_hs[k]) begin
                cnt_d[k] = cnt_q[k] + CntW'(1);
            end else if (!a_hs[k] && d_hs[k] && cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - CntW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef TLUL_ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
`ifdef TLUL_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Self-checking bench for tlul_host_arb2: directed scenarios plus a randomized run against a transaction-level model.
module tb_tlul_host_arb2;

    localparam int MaxO = 2;
`ifdef TLUL_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [101:0] h0, h1, dvo;
    logic [67:0]  h0o, h1o, dvi;
    logic         busy;

    int n_cmp;
    int n_fail;

    // Model: outstanding per host, locked owner (-1 none), host preferred on a tie.
    int m_cnt [2];
    int m_lock;
    int m_rr;

    tlul_host_arb2 #(.MaxOutstanding(MaxO)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_h0_i(h0),
        .tl_h0_o(h0o),
        .tl_h1_i(h1),
        .tl_h1_o(h1o),
        .tl_d_o (dvo),
        .tl_d_i (dvi),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [101:0] mk_a(input logic [2:0] op, input logic [7:0] src,
                                          input logic [31:0] addr, input logic [31:0] data,
                                          input logic dr);
        return {1'b1, op, 3'b000, 2'd2, src, addr, 4'hf, data, 16'h0000, dr};
    endfunction

    function automatic logic [67:0] mk_d(input logic [2:0] op, input logic [7:0] src,
                                         input logic [31:0] data, input logic ar);
        return {1'b1, op, 3'b000, 2'd2, src, 1'b0, data, 16'h0000, 1'b0, ar};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [101:0] host_bus(input int k);
        return (k == 1) ? h1 : h0;
    endfunction

    function automatic int exp_grant();
        bit e0, e1;
        if (m_lock >= 0) return m_lock;
        e0 = h0[101] && (m_cnt[0] < MaxO);
        e1 = h1[101] && (m_cnt[1] < MaxO);
        if (e0 && e1) return RrEn ? m_rr : 1;
        if (e1) return 1;
        if (e0) return 0;
        return -1;
    endfunction

    function automatic logic [101:0] exp_dev(input int g);
        logic [101:0] b;
        b = '0;
        if (g >= 0) begin
            b = host_bus(g);
            b[92] = (g == 1);
        end
        b[0] = dvi[58] ? h1[0] : h0[0];
        return b;
    endfunction

    // Advance one clock and update the model from the inputs seen before the edge.
    task automatic tick();
        int g;
        bit ahs [2];
        bit dhs [2];
        logic [101:0] hb;
        g = exp_grant();
        for (int k = 0; k < 2; k++) begin
            hb     = host_bus(k);
            ahs[k] = (g == k) && hb[101] && dvi[0];
            dhs[k] = dvi[67] && (int'(dvi[58]) == k) && hb[0];
        end
        @(posedge clk);
        if (rst) begin
            m_cnt[0] = 0; m_cnt[1] = 0; m_lock = -1; m_rr = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ahs[k] && !dhs[k]) m_cnt[k]++;
                else if (!ahs[k] && dhs[k] && m_cnt[k] > 0) m_cnt[k]--;
            end
            if (g >= 0) begin
                if (ahs[g]) begin m_lock = -1; m_rr = 1 - g; end
                else m_lock = g;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; h0 = '0; h1 = '0; dvi = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (h0o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_h0_aready: got %0b want 0", h0o[0]); end
        n_cmp++; if (h0o[67] !== 1'b0) begin n_fail++; $display("FAIL reset_h0_dvalid: got %0b want 0", h0o[67]); end
        n_cmp++; if (h1o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_h1_aready: got %0b want 0", h1o[0]); end
        n_cmp++; if (h1o[67] !== 1'b0) begin n_fail++; $display("FAIL reset_h1_dvalid: got %0b want 0", h1o[67]); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (dvo[101] !== 1'b0) begin n_fail++; $display("FAIL reset_dev_avalid: got %0b want 0", dvo[101]); end
    endtask

    task automatic test_single_get();
        do_reset();
        h0 = mk_a(3'd4, 8'h00, 32'h100, 32'h0, 1'b1);
        dvi = 68'h1;
        #1;
        n_cmp++; if (dvo[101] !== 1'b1) begin n_fail++; $display("FAIL get_avalid: got %0b want 1", dvo[101]); end
        n_cmp++; if (dvo[92:85] !== 8'h00) begin n_fail++; $display("FAIL get_source: got %h want 00", dvo[92:85]); end
        n_cmp++; if (dvo[84:53] !== 32'h100) begin n_fail++; $display("FAIL get_addr: got %h want 100", dvo[84:53]); end
        n_cmp++; if (h0o[0] !== 1'b1) begin n_fail++; $display("FAIL get_h0_aready: got %0b want 1", h0o[0]); end
        n_cmp++; if (h1o[0] !== 1'b0) begin n_fail++; $display("FAIL get_h1_aready: got %0b want 0", h1o[0]); end
        tick();
        h0 = 102'h1;
        dvi = mk_d(3'd1, 8'h00, 32'hDEADBEEF, 1'b0);
        #1;
        n_cmp++; if (h0o[67] !== 1'b1) begin n_fail++; $display("FAIL get_h0_dvalid: got %0b want 1", h0o[67]); end
        n_cmp++; if (h0o[49:18] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL get_h0_ddata: got %h want deadbeef", h0o[49:18]); end
        n_cmp++; if (h1o[67] !== 1'b0) begin n_fail++; $display("FAIL get_h1_dvalid: got %0b want 0", h1o[67]); end
        n_cmp++; if (dvo[0] !== 1'b1) begin n_fail++; $display("FAIL get_dev_dready: got %0b want 1", dvo[0]); end
        tick();
        h0 = '0; dvi = '0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL get_busy_after: got %0b want 0", busy); end
    endtask

    task automatic test_hold_grant();
        logic       w;
        logic [7:0] src;
        logic [31:0] addr;
        do_reset();
        w    = RrEn ? 1'b0 : 1'b1;
        src  = w ? 8'h89 : 8'h05;
        addr = w ? 32'h300 : 32'h200;
        h0 = mk_a(3'd4, 8'h05, 32'h200, 32'h0, 1'b1);
        h1 = mk_a(3'd4, 8'h09, 32'h300, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            dvi = {67'h0, (i == 3)};
            #1;
            n_cmp++; if (dvo[92:85] !== src) begin n_fail++; $display("FAIL hold_source[%0d]: got %h want %h", i, dvo[92:85], src); end
            n_cmp++; if (dvo[84:53] !== addr) begin n_fail++; $display("FAIL hold_addr[%0d]: got %h want %h", i, dvo[84:53], addr); end
            n_cmp++; if ((w ? h1o[0] : h0o[0]) !== (i == 3)) begin n_fail++; $display("FAIL hold_win_aready[%0d]: got %0b want %0b", i, w ? h1o[0] : h0o[0], i == 3); end
            n_cmp++; if ((w ? h0o[0] : h1o[0]) !== 1'b0) begin n_fail++; $display("FAIL hold_lose_aready[%0d]: got %0b want 0", i, w ? h0o[0] : h1o[0]); end
            tick();
        end
        if (w) h1 = '0; else h0 = '0;
        #1;
        n_cmp++; if (dvo[92] !== ~w) begin n_fail++; $display("FAIL hold_next_owner: got %0b want %0b", dvo[92], ~w); end
        tick();
    endtask

    task automatic test_priority();
        logic e;
        do_reset();
        h0 = mk_a(3'd4, 8'h11, 32'h700, 32'h0, 1'b1);
        h1 = mk_a(3'd4, 8'h22, 32'h800, 32'h0, 1'b1);
        dvi = 68'h1;
        for (int i = 0; i < 4; i++) begin
            e = RrEn ? ((i % 2) == 1) : (i < 2);
            #1;
            n_cmp++; if (dvo[92] !== e) begin n_fail++; $display("FAIL prio_owner[%0d]: got %0b want %0b", i, dvo[92], e); end
            tick();
        end
    endtask

    task automatic test_max_outstanding();
        do_reset();
        h0 = mk_a(3'd4, 8'h01, 32'h400, 32'h0, 1'b1);
        dvi = 68'h1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (h0o[0] !== 1'b1) begin n_fail++; $display("FAIL maxo_accept[%0d]: got %0b want 1", i, h0o[0]); end
            tick();
        end
        h1 = mk_a(3'd4, 8'h02, 32'h500, 32'h0, 1'b1);
        #1;
        n_cmp++; if (dvo[101] !== 1'b1 || dvo[92] !== 1'b1) begin n_fail++; $display("FAIL maxo_h1_granted: got v%0b s%0b want v1 s1", dvo[101], dvo[92]); end
        n_cmp++; if (h0o[0] !== 1'b0) begin n_fail++; $display("FAIL maxo_h0_blocked: got %0b want 0", h0o[0]); end
        tick();
        h1 = '0;
        dvi = mk_d(3'd1, 8'h00, 32'h0, 1'b1);
        #1;
        n_cmp++; if (dvo[101] !== 1'b0) begin n_fail++; $display("FAIL maxo_still_blocked: got %0b want 0", dvo[101]); end
        n_cmp++; if (h0o[67] !== 1'b1) begin n_fail++; $display("FAIL maxo_d_return: got %0b want 1", h0o[67]); end
        tick();
        dvi = 68'h1;
        #1;
        n_cmp++; if (dvo[101] !== 1'b1 || dvo[92] !== 1'b0) begin n_fail++; $display("FAIL maxo_reenable: got v%0b s%0b want v1 s0", dvo[101], dvo[92]); end
        n_cmp++; if (h0o[0] !== 1'b1) begin n_fail++; $display("FAIL maxo_reenable_aready: got %0b want 1", h0o[0]); end
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        h1 = mk_a(3'd0, 8'h03, 32'h600, 32'h1234, 1'b1);
        dvi = 68'h1;
        #1;
        n_cmp++; if (h1o[0] !== 1'b1) begin n_fail++; $display("FAIL same_first: got %0b want 1", h1o[0]); end
        tick();
        dvi = mk_d(3'd0, 8'h83, 32'h0, 1'b1);
        #1;
        n_cmp++; if (h1o[67] !== 1'b1 || h1o[0] !== 1'b1) begin n_fail++; $display("FAIL same_both_hs: got d%0b a%0b want d1 a1", h1o[67], h1o[0]); end
        n_cmp++; if (h1o[58:51] !== 8'h03) begin n_fail++; $display("FAIL same_dsource: got %h want 03", h1o[58:51]); end
        n_cmp++; if (h0o[67] !== 1'b0) begin n_fail++; $display("FAIL same_h0_dvalid: got %0b want 0", h0o[67]); end
        tick();
        h1 = 102'h1; dvi = '0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL same_busy: got %0b want 1", busy); end
        dvi = mk_d(3'd0, 8'h83, 32'h0, 1'b0);
        tick();
        dvi = '0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_drain_busy: got %0b want 0", busy); end
    endtask

    task automatic test_reset_hold();
        do_reset();
        h0 = mk_a(3'd4, 8'h01, 32'h900, 32'h0, 1'b1);
        dvi = 68'h1;
        tick(); tick();
        h1 = mk_a(3'd4, 8'h02, 32'hA00, 32'h0, 1'b1);
        tick();
        dvi = '0;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rsthold_busy_before: got %0b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        h1 = '0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsthold_busy: got %0b want 0", busy); end
        n_cmp++; if (dvo[101] !== 1'b1 || dvo[92] !== 1'b0) begin n_fail++; $display("FAIL rsthold_idle_grant: got v%0b s%0b want v1 s0", dvo[101], dvo[92]); end
        n_cmp++; if (h1o[0] !== 1'b0) begin n_fail++; $display("FAIL rsthold_h1_aready: got %0b want 0", h1o[0]); end
        tick();
    endtask

    task automatic test_random();
        int g;
        logic [127:0] r;
        logic [101:0] ed;
        logic [67:0]  sel_o, oth_o, ers;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_lock != 0) begin r = rand128(); h0 = r[101:0]; h0[101] = ($urandom_range(0, 9) < 7); end
            if (m_lock != 1) begin r = rand128(); h1 = r[101:0]; h1[101] = ($urandom_range(0, 9) < 7); end
            h0[0] = 1'($urandom_range(0, 1));
            h1[0] = 1'($urandom_range(0, 1));
            r = rand128(); dvi = r[67:0];
            dvi[67] = ($urandom_range(0, 9) < 4);
            #1;
            g  = exp_grant();
            ed = exp_dev(g);
            ers = dvi; ers[58] = 1'b0;
            sel_o = dvi[58] ? h1o : h0o;
            oth_o = dvi[58] ? h0o : h1o;
            n_cmp++; if (dvo !== ed) begin n_fail++; $display("FAIL rnd_dev[%0d]: got %h want %h", i, dvo, ed); end
            n_cmp++; if (h0o[0] !== (g == 0 && dvi[0])) begin n_fail++; $display("FAIL rnd_h0_aready[%0d]: got %0b want %0b", i, h0o[0], g == 0 && dvi[0]); end
            n_cmp++; if (h1o[0] !== (g == 1 && dvi[0])) begin n_fail++; $display("FAIL rnd_h1_aready[%0d]: got %0b want %0b", i, h1o[0], g == 1 && dvi[0]); end
            n_cmp++; if (sel_o[67:1] !== ers[67:1]) begin n_fail++; $display("FAIL rnd_dfields[%0d]: got %h want %h", i, sel_o[67:1], ers[67:1]); end
            n_cmp++; if (oth_o[67] !== 1'b0) begin n_fail++; $display("FAIL rnd_other_dvalid[%0d]: got %0b want 0", i, oth_o[67]); end
            n_cmp++; if (busy !== (m_cnt[0] != 0 || m_cnt[1] != 0)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %0b want %0b", i, busy, m_cnt[0] != 0 || m_cnt[1] != 0); end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_lock = -1; m_rr = 0;
        rst = 1'b1; h0 = '0; h1 = '0; dvi = '0;
        #1;
        test_reset();
        test_single_get();
        test_hold_grant();
        test_priority();
        test_max_outstanding();
        test_same_cycle();
        test_reset_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
